tile_local_pkt_fifo: RTL and testbench
======================================

# tile_local_pkt_fifo

Store-and-forward packet buffer on the tile's local NoC ingress path, between the switch local output port and the loop accelerator input. It accepts AXI-Stream words from the switch and holds each packet until its TLAST beat is stored. It then releases the whole packet downstream at one word per cycle, so the accelerator never sees a partial packet stalled mid-stream by the NoC. Occupancy and packet-count status go to the tile control registers.

## Interface
- BW, 32, stream data width in bits
- BWB, BW/8, TKEEP width
- NOC_BUFFER_ADDR_W, 8, log2 of buffer depth; DEPTH = 2**NOC_BUFFER_ADDR_W words
- clk_line  in  1  line clock; all logic on its rising edge
- clk_line_rst_low  in  1  reset, asynchronous assert, active-low
- stream_in_TVALID  in  1  word valid from switch local out
- stream_in_TDATA  in  BW  word data
- stream_in_TKEEP  in  BWB  byte enables, stored unmodified
- stream_in_TLAST  in  1  last word of packet
- stream_in_TREADY  out  1  buffer can accept a word
- stream_out_TVALID  out  1  word valid to accelerator
- stream_out_TDATA  out  BW  word data
- stream_out_TKEEP  out  BWB  byte enables
- stream_out_TLAST  out  1  last word of packet
- stream_out_TREADY  in  1  accelerator accepts word
- level  out  NOC_BUFFER_ADDR_W+1  words held, including the output register
- pkt_count  out  NOC_BUFFER_ADDR_W+1  complete packets held, not yet fully drained
- cut_through  out  1  deadlock-escape mode active

## Operation
- Storage: DEPTH entries of {TLAST, TKEEP, TDATA}, circular write and read pointers of NOC_BUFFER_ADDR_W bits that wrap modulo DEPTH, plus one registered output stage.
- Write: a word is stored when stream_in_TVALID && stream_in_TREADY. stream_in_TREADY = (level < DEPTH), taken from registered level.
- pkt_count increments on every accepted input word with TLAST=1. It decrements on every accepted output word with TLAST=1. Both in the same cycle leaves it unchanged.
- Release state machine, states IDLE, SEND, CUT:
  - IDLE: output register empty or holding nothing eligible. Go to SEND when pkt_count > 0. Go to CUT when level == DEPTH and pkt_count == 0.
  - SEND: output register loads the next stored word whenever it is empty or being accepted. Load stops after a TLAST word is loaded. Return to IDLE when that TLAST word is accepted downstream. If pkt_count > 0 after the decrement, go straight back to SEND; no bubble is required.
  - CUT: cut_through=1. Words are released as they arrive, without waiting for TLAST. Exit to IDLE when the TLAST word is accepted downstream.
- level increments on an input accept and decrements on an output accept. Simultaneous accepts leave level unchanged. level never exceeds DEPTH.
- stream_out_TVALID/TDATA/TKEEP/TLAST hold stable while TVALID=1 and TREADY=0.
- Reset (asynchronous, active-low): pointers, level, pkt_count = 0; state IDLE; stream_out_TVALID=0, stream_out_TDATA=0, stream_out_TKEEP=0, stream_out_TLAST=0, stream_in_TREADY=0 while reset is held, cut_through=0. Reset mid-packet discards all stored and partial packets. The first accepted word after reset starts a new packet.

## Timing
- stream_in_TREADY rises 1 cycle after reset deasserts.
- TLAST word accepted at edge N: pkt_count updates at N+1, stream_out_TVALID is first high after edge N+2. Minimum packet latency, single-word packet: 2 cycles.
- Sustained throughput 1 word/cycle in and out simultaneously, including back-to-back packets.
- Full: with level == DEPTH, stream_in_TREADY=0 in the following cycle. It returns high the cycle after any output accept.
- Empty: stream_out_TVALID=0 whenever no eligible word is stored; TVALID never drops mid-packet in SEND.

## Test plan
- Single packet of 4 words (data 0x11..0x44, TKEEP 0xF, TLAST on 0x44), sink always ready -> out TVALID first high 2 cycles after TLAST accept; words in order; pkt_count goes 0→1→0; level returns to 0.
- 3-word packet with input TVALID held low 5 cycles between words 2 and 3 -> no output until the TLAST word is stored; output then contiguous, 3 cycles.
- Back-to-back packets of 2 and 3 words, with sink TREADY toggling 1/0 each cycle -> 5 words delivered in order; TLAST on words 2 and 5; data stable while stalled; pkt_count peaks at 2.
- NOC_BUFFER_ADDR_W=3, a 12-word packet, sink held not ready until level=8 -> stream_in_TREADY=0, cut_through=1; releasing the sink drains all 12 words correctly and cut_through clears after the TLAST word.
- Pointer wrap: NOC_BUFFER_ADDR_W=3, 20 packets of 3 words streamed continuously -> all 60 words intact, no drops, level ≤ 8.
- Reset asserted after 2 words of a 4-word packet -> outputs zero immediately; level=0, pkt_count=0; the next 1-word packet is delivered alone, with no stale data.

Source files
------------

// File: rtl/tile_local_pkt_fifo.sv
// Store-and-forward packet buffer for the tile-local NoC ingress path.
// A packet is released downstream only once its TLAST word is stored, unless the buffer fills first.
module tile_local_pkt_fifo #(
   parameter int BW                = 32,
   parameter int BWB               = BW / 8,
   parameter int NOC_BUFFER_ADDR_W = 8
) (
   input  logic                         clk_line,
   input  logic                         clk_line_rst_low,
   input  logic                         stream_in_TVALID,
   input  logic [BW-1:0]                stream_in_TDATA,
   input  logic [BWB-1:0]               stream_in_TKEEP,
   input  logic                         stream_in_TLAST,
   output logic                         stream_in_TREADY,
   output logic                         stream_out_TVALID,
   output logic [BW-1:0]                stream_out_TDATA,
   output logic [BWB-1:0]               stream_out_TKEEP,
   output logic                         stream_out_TLAST,
   input  logic                         stream_out_TREADY,
   output logic [NOC_BUFFER_ADDR_W:0]   level,
   output logic [NOC_BUFFER_ADDR_W:0]   pkt_count,
   output logic                         cut_through
);

   localparam int AW    = NOC_BUFFER_ADDR_W;
   localparam int DEPTH = 2 ** AW;
   localparam int EW    = 1 + BWB + BW;
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SEND, CUT} state_t;

   logic [EW-1:0]  r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [AW:0]    r_level, r_pkt_count;
   logic           r_rdy_en;
   state_t         r_state, w_state_nxt;
   logic           r_out_valid, r_out_last, r_last_loaded;
   logic [BW-1:0]  r_out_data;
   logic [BWB-1:0] r_out_keep;

   logic           w_in_acc, w_out_acc, w_in_last_acc, w_out_last_acc;
   logic           w_mem_ne, w_room, w_chain, w_load, w_release, w_cut;
   logic [AW:0]    w_mem_cnt, w_pkt_nxt;
   logic [EW-1:0]  w_rd_word;

   assign stream_in_TREADY = r_rdy_en && (r_level != FULL_LVL);
   assign w_in_acc         = stream_in_TVALID && stream_in_TREADY;
   assign w_out_acc        = r_out_valid && stream_out_TREADY;
   assign w_in_last_acc    = w_in_acc && stream_in_TLAST;
   assign w_out_last_acc   = w_out_acc && r_out_last;
   assign w_pkt_nxt        = r_pkt_count + {{AW{1'b0}}, w_in_last_acc} - {{AW{1'b0}}, w_out_last_acc};

   // Words in memory exclude the one parked in the output register.
   assign w_mem_cnt = r_level - {{AW{1'b0}}, r_out_valid};
   assign w_mem_ne  = (w_mem_cnt != '0);
   assign w_rd_word = r_mem[r_rd_ptr];
   assign w_room    = !r_out_valid || w_out_acc;
   // Chaining: a further complete packet already sits in memory, so load it as this TLAST leaves.
   assign w_chain   = (r_state == SEND) && w_out_last_acc && (r_pkt_count > ONE);
   assign w_load    = w_release && w_mem_ne && w_room && (!r_last_loaded || w_chain);

   always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
      if (!clk_line_rst_low) r_state <= IDLE;
      else                   r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_pkt_count != '0)         w_state_nxt = SEND;
            else if (r_level == FULL_LVL)  w_state_nxt = CUT;
         end
         SEND: if (w_out_last_acc) w_state_nxt = (w_pkt_nxt != '0) ? SEND : IDLE;
         CUT:  if (w_out_last_acc) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_release = 1'b0;
      w_cut     = 1'b0;
      case (r_state)
         SEND:    w_release = 1'b1;
         CUT: begin
            w_release = 1'b1;
            w_cut     = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
      if (!clk_line_rst_low) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_pkt_count   <= '0;
         r_rdy_en      <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_last    <= 1'b0;
         r_out_data    <= '0;
         r_out_keep    <= '0;
         r_last_loaded <= 1'b0;
      end else begin
         r_rdy_en    <= 1'b1;
         r_pkt_count <= w_pkt_nxt;
         if (w_in_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_load)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_in_acc, w_out_acc})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: ;
         endcase
         if (w_load) begin
            r_out_valid                          <= 1'b1;
            {r_out_last, r_out_keep, r_out_data} <= w_rd_word;
            r_last_loaded                        <= w_rd_word[EW-1];
         end else begin
            if (w_out_acc)      r_out_valid   <= 1'b0;
            if (w_out_last_acc) r_last_loaded <= 1'b0;
         end
      end
   end

   // NOTE: storage array carries no reset; pointers and level alone define what is valid.
   always_ff @(posedge clk_line) begin
      if (w_in_acc) r_mem[r_wr_ptr] <= {stream_in_TLAST, stream_in_TKEEP, stream_in_TDATA};
   end

   assign stream_out_TVALID = r_out_valid;
   assign stream_out_TDATA  = r_out_data;
   assign stream_out_TKEEP  = r_out_keep;
   assign stream_out_TLAST  = r_out_last;
   assign level             = r_level;
   assign pkt_count         = r_pkt_count;
   assign cut_through       = w_cut;

endmodule

// File: tb/tb_tile_local_pkt_fifo.sv
// Scoreboard bench for tile_local_pkt_fifo with an 8-entry buffer (address width 3).
// Accepted input words are queued as expectations and popped on each output handshake.
module tb_tile_local_pkt_fifo;

   localparam int BW = 32, BWB = 4, AW = 3, DEPTH = 8;

   typedef struct packed {
      logic           last;
      logic [BWB-1:0] keep;
      logic [BW-1:0]  data;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_last, in_ready;
   logic [BW-1:0]  in_data;
   logic [BWB-1:0] in_keep;
   logic           out_valid, out_last, out_ready;
   logic [BW-1:0]  out_data;
   logic [BWB-1:0] out_keep;
   logic [AW:0]    level, pkt_count;
   logic           cut_through;

   beat_t exp_q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int t_last, first_valid_cyc, first_acc_cyc, last_acc_cyc, pkt_peak, lvl_peak, in_stalls;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tile_local_pkt_fifo #(.BW(BW), .BWB(BWB), .NOC_BUFFER_ADDR_W(AW)) dut (
      .clk_line(clk), .clk_line_rst_low(rst_n),
      .stream_in_TVALID(in_valid), .stream_in_TDATA(in_data), .stream_in_TKEEP(in_keep),
      .stream_in_TLAST(in_last), .stream_in_TREADY(in_ready),
      .stream_out_TVALID(out_valid), .stream_out_TDATA(out_data), .stream_out_TKEEP(out_keep),
      .stream_out_TLAST(out_last), .stream_out_TREADY(out_ready),
      .level(level), .pkt_count(pkt_count), .cut_through(cut_through)
   );

   task automatic send_word(input logic [BW-1:0] d, input logic [BWB-1:0] k, input logic l);
      int w = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
      while (!in_ready && w < 500) begin
         @(negedge clk);
         w++;
         in_stalls++;
      end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", w);
      end else begin
         exp_q.push_back(beat_t'({l, k, d}));
         if (l) t_last = cyc + 1;
      end
   endtask

   task automatic idle_in();
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_keep = '0;
   endtask

   // mode 0: sink always ready; 1: ready toggles each cycle; 2: hold off until level==DEPTH.
   task automatic collect(input int n, input int mode, input string tag);
      beat_t got, prev, exp;
      logic prev_stall = 1'b0, released;
      int got_n = 0, waited = 0;
      released = (mode != 2);
      prev = '0; first_valid_cyc = -1; pkt_peak = 0; lvl_peak = 0;
      while (got_n < n && waited < 2000) begin
         @(negedge clk);
         waited++;
         if (int'(pkt_count) > pkt_peak) pkt_peak = int'(pkt_count);
         if (int'(level) > lvl_peak) lvl_peak = int'(level);
         if (mode == 2 && int'(level) == DEPTH) released = 1'b1;
         out_ready = (mode == 1) ? cyc[0] : released;
         got = {out_last, out_keep, out_data};
         if (prev_stall) begin
            n_cmp++;
            if (!out_valid || got !== prev) begin
               n_bad++;
               $display("FAIL %s_stable: got v=%b %h, required v=1 %h", tag, out_valid, got, prev);
            end
         end
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL %s_extra: got word %h, required none", tag, got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin
                  n_bad++;
                  $display("FAIL %s_word%0d: got %h, required %h", tag, got_n, got, exp);
               end
            end
            if (got_n == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            got_n++;
         end
         prev_stall = out_valid && !out_ready;
         prev = got;
      end
      if (got_n < n) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_timeout: got %0d words, required %0d", tag, got_n, n);
      end
      @(negedge clk);
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_keep = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({out_valid, out_data, out_keep, out_last, level, pkt_count, cut_through, in_ready} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: v=%b d=%h k=%h l=%b lvl=%0d pc=%0d ct=%b rdy=%b, required all 0",
                  out_valid, out_data, out_keep, out_last, level, pkt_count, cut_through, in_ready);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_early: got %b, required 0", in_ready); end
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_rise: got %b, required 1", in_ready); end
      out_ready = 1'b1;
   endtask

   task automatic test_single();
      fork
         begin
            for (int i = 1; i <= 4; i++) send_word(32'h11 * i, 4'hF, i == 4);
            idle_in();
            n_cmp++;
            if (pkt_count !== 4'd1) begin n_bad++; $display("FAIL single_pkt_up: got %0d, required 1", pkt_count); end
         end
         collect(4, 0, "single");
      join
      n_cmp++;
      if (first_valid_cyc != t_last + 2) begin
         n_bad++;
         $display("FAIL single_latency: got %0d, required %0d", first_valid_cyc - t_last, 2);
      end
      n_cmp++;
      if (level !== '0 || pkt_count !== '0) begin
         n_bad++;
         $display("FAIL single_drain: got lvl=%0d pc=%0d, required 0 0", level, pkt_count);
      end
   endtask

   task automatic test_gap();
      fork
         begin
            send_word(32'hA1, 4'h3, 1'b0);
            send_word(32'hA2, 4'hC, 1'b0);
            repeat (5) idle_in();
            send_word(32'hA3, 4'h1, 1'b1);
            idle_in();
         end
         collect(3, 0, "gap");
      join
      n_cmp++;
      if (first_valid_cyc != t_last + 2) begin
         n_bad++;
         $display("FAIL gap_early_out: got %0d cycles after TLAST, required 2", first_valid_cyc - t_last);
      end
      n_cmp++;
      if (last_acc_cyc - first_acc_cyc != 2) begin
         n_bad++;
         $display("FAIL gap_contiguous: got span %0d, required 2", last_acc_cyc - first_acc_cyc);
      end
   endtask

   task automatic test_back_to_back();
      fork
         begin
            for (int i = 1; i <= 5; i++) send_word(32'hB0 + i, 4'(i), (i == 2) || (i == 5));
            idle_in();
         end
         collect(5, 1, "b2b");
      join
      n_cmp++;
      if (pkt_peak != 2) begin n_bad++; $display("FAIL b2b_pkt_peak: got %0d, required 2", pkt_peak); end
   endtask

   task automatic test_cut_through();
      fork
         begin
            for (int i = 0; i < 12; i++) send_word(32'hC00 + i, 4'hF, i == 11);
            idle_in();
         end
         collect(12, 2, "cut");
         begin
            int w = 0;
            while (int'(level) != DEPTH && w < 200) begin @(negedge clk); w++; end
            n_cmp++;
            if (in_ready !== 1'b0 || int'(level) != DEPTH) begin
               n_bad++;
               $display("FAIL cut_full_ready: got rdy=%b lvl=%0d, required 0 %0d", in_ready, level, DEPTH);
            end
            @(negedge clk);
            n_cmp++;
            if (cut_through !== 1'b1) begin n_bad++; $display("FAIL cut_enter: got %b, required 1", cut_through); end
         end
      join
      n_cmp++;
      if (cut_through !== 1'b0 || level !== '0 || pkt_count !== '0) begin
         n_bad++;
         $display("FAIL cut_exit: got ct=%b lvl=%0d pc=%0d, required 0 0 0", cut_through, level, pkt_count);
      end
   endtask

   task automatic test_wrap();
      in_stalls = 0;
      fork
         begin
            for (int p = 0; p < 20; p++)
               for (int w = 0; w < 3; w++)
                  send_word({16'hD000 + 16'(p), 16'(w)}, 4'(p + w + 1), w == 2);
            idle_in();
         end
         collect(60, 0, "wrap");
      join
      n_cmp++;
      if (in_stalls != 0 || lvl_peak > DEPTH) begin
         n_bad++;
         $display("FAIL wrap_flow: got stalls=%0d peak=%0d, required 0 and <=%0d", in_stalls, lvl_peak, DEPTH);
      end
      n_cmp++;
      if (last_acc_cyc - first_acc_cyc != 59) begin
         n_bad++;
         $display("FAIL wrap_throughput: got span %0d, required 59", last_acc_cyc - first_acc_cyc);
      end
   endtask

   task automatic test_reset_mid_packet();
      bit seen = 1'b0;
      send_word(32'hE0, 4'hF, 1'b0);
      send_word(32'hE1, 4'hF, 1'b0);
      idle_in();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, out_data, out_keep, out_last, level, pkt_count, in_ready} !== '0) begin
         n_bad++;
         $display("FAIL midrst_zero: v=%b d=%h lvl=%0d pc=%0d rdy=%b, required all 0",
                  out_valid, out_data, level, pkt_count, in_ready);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fork
         begin
            send_word(32'hF1, 4'h5, 1'b1);
            idle_in();
         end
         collect(1, 0, "midrst");
      join
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen || level !== '0) begin
         n_bad++;
         $display("FAIL midrst_stale: got extra_valid=%b lvl=%0d, required 0 0", seen, level);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_gap();
      test_back_to_back();
      test_cut_through();
      test_wrap();
      test_reset_mid_packet();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
